// File: rtl/acc_trunc_stage_if.sv
// acc_trunc_stage_if
// Bundles the op-issue and drain signals of the PE add/truncate stage.
// master: upstream controller (multiply stage + drain sequencer).
// slave : acc_trunc_stage.
interface acc_trunc_stage_if #(
  parameter int DATA_W   = 16,
  parameter int ACT_NO_W = 6,
  parameter int TRUNC_W  = 4
);

  logic [1:0]          comp_en_add;
  logic [ACT_NO_W-1:0] out_act_addr_add;
  logic [TRUNC_W-1:0]  trunc_amount_add;
  logic [2*DATA_W-1:0] mult_result_add;
  logic                rd_en;
  logic [ACT_NO_W-1:0] rd_addr;
  logic [DATA_W-1:0]   rd_data;
  logic                rd_valid;
  logic                busy;
  logic                sat_flag;

  modport master (
    output comp_en_add,
    output out_act_addr_add,
    output trunc_amount_add,
    output mult_result_add,
    output rd_en,
    output rd_addr,
    input  rd_data,
    input  rd_valid,
    input  busy,
    input  sat_flag
  );

  modport slave (
    input  comp_en_add,
    input  out_act_addr_add,
    input  trunc_amount_add,
    input  mult_result_add,
    input  rd_en,
    input  rd_addr,
    output rd_data,
    output rd_valid,
    output busy,
    output sat_flag
  );

endinterface

// File: rtl/acc_trunc_stage.sv
// acc_trunc_stage
// Add stage of the PE pipeline. Three stages:
//   T : shift the signed product right, clamp to DATA_W, register value/addr/op
//   R : synchronous read of psum[addr] (forwarded from W on an address hit)
//   W : LOAD or saturating ACC, written back into the psum array
// A drain port reads committed psum contents one cycle after rd_en.
// Optional build macro: TRUNC_ROUND_EN -- round-half-up before the shift
// instead of plain truncation toward negative infinity.
module acc_trunc_stage #(
  parameter int DATA_W   = 16,
  parameter int ACT_NO_W = 6,
  parameter int TRUNC_W  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  acc_trunc_stage_if.slave bus
);

  localparam int PW    = 2 * DATA_W;
  localparam int DEPTH = 2 ** ACT_NO_W;

  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    OP_IDLE = 2'd0,
    OP_ACC  = 2'd1,
    OP_LOAD = 2'd2,
    OP_RSVD = 2'd3
  } op_e;

  // Only ACC and LOAD touch the array or the saturation flag; the reserved
  // code still occupies the pipe so busy reflects it.
  function automatic logic op_active(input op_e op);
    return (op == OP_ACC) || (op == OP_LOAD);
  endfunction

  // Stage T registers
  op_e                 op_t_q,   op_t_d;
  logic [ACT_NO_W-1:0] addr_t_q, addr_t_d;
  logic [DATA_W-1:0]   val_t_q,  val_t_d;

  // Stage R registers
  op_e                 op_r_q,   op_r_d;
  logic [ACT_NO_W-1:0] addr_r_q, addr_r_d;
  logic [DATA_W-1:0]   val_r_q,  val_r_d;
  logic [DATA_W-1:0]   psum_r_q, psum_r_d;

  // Stage W occupancy (the write itself lands on the edge entering W)
  op_e                 op_w_q,   op_w_d;

  // Partial-sum array and drain port
  logic [DATA_W-1:0]   psum_q [DEPTH];
  logic [DATA_W-1:0]   rd_data_q,  rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                sat_flag_q, sat_flag_d;

  // Shift/clamp datapath
  op_e                 op_in;
  logic signed [PW:0]  prod_ext;
  logic signed [PW:0]  rnd_add;
  logic signed [PW:0]  shifted;
  logic                t_hi, t_lo;
  logic [DATA_W-1:0]   t_val;

  // Accumulate datapath
  logic [DATA_W:0]     sum_ext;
  logic                w_hi, w_lo;
  logic [DATA_W-1:0]   sum_w;
  logic                w_we;
  logic                fwd;

`ifdef TRUNC_ROUND_EN
  localparam logic signed [PW:0] RND_ONE = {{PW{1'b0}}, 1'b1};
`endif

  // T: sign-extend one bit so the rounding add cannot overflow, shift, clamp
  always_comb begin
    op_in    = op_e'(bus.comp_en_add);
    prod_ext = {bus.mult_result_add[PW-1], bus.mult_result_add};
    rnd_add  = '0;
`ifdef TRUNC_ROUND_EN
    if (bus.trunc_amount_add != '0) begin
      rnd_add = RND_ONE << (bus.trunc_amount_add - TRUNC_W'(1));
    end
`endif
    shifted = (prod_ext + rnd_add) >>> bus.trunc_amount_add;
    // Fits in DATA_W only when every bit from DATA_W-1 upward matches the sign
    t_hi    = ~shifted[PW] & (|shifted[PW-1:DATA_W-1]);
    t_lo    =  shifted[PW] & ~(&shifted[PW-1:DATA_W-1]);
    if (t_hi) begin
      t_val = SAT_MAX;
    end else if (t_lo) begin
      t_val = SAT_MIN;
    end else begin
      t_val = shifted[DATA_W-1:0];
    end
  end

  // W: LOAD passes the value through, ACC adds in DATA_W+1 bits then clamps
  always_comb begin
    if (op_r_q == OP_LOAD) begin
      sum_ext = {val_r_q[DATA_W-1], val_r_q};
    end else begin
      sum_ext = {psum_r_q[DATA_W-1], psum_r_q} + {val_r_q[DATA_W-1], val_r_q};
    end
    w_hi = ~sum_ext[DATA_W] &  sum_ext[DATA_W-1];
    w_lo =  sum_ext[DATA_W] & ~sum_ext[DATA_W-1];
    if (w_hi) begin
      sum_w = SAT_MAX;
    end else if (w_lo) begin
      sum_w = SAT_MIN;
    end else begin
      sum_w = sum_ext[DATA_W-1:0];
    end
    w_we = op_active(op_r_q);
  end

  // Next-state for the pipe, the forwarding mux, drain port and sticky flag
  always_comb begin
    op_t_d   = op_in;
    addr_t_d = bus.out_act_addr_add;
    val_t_d  = t_val;

    // The op leaving R writes on the same edge this read is captured, so an
    // address hit must take the fresh sum rather than the stale array entry.
    fwd      = w_we && (addr_r_q == addr_t_q);
    op_r_d   = op_t_q;
    addr_r_d = addr_t_q;
    val_r_d  = val_t_q;
    psum_r_d = psum_r_q;
    if (op_active(op_t_q)) begin
      psum_r_d = fwd ? sum_w : psum_q[addr_t_q];
    end

    op_w_d = op_r_q;

    rd_valid_d = bus.rd_en;
    rd_data_d  = bus.rd_en ? psum_q[bus.rd_addr] : rd_data_q;

    sat_flag_d = sat_flag_q
               | (op_active(op_in) & (t_hi | t_lo))
               | (w_we & (w_hi | w_lo));
  end

  // Pipeline stage registers; reset drops any in-flight op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_t_q     <= OP_IDLE;
      addr_t_q   <= '0;
      val_t_q    <= '0;
      op_r_q     <= OP_IDLE;
      addr_r_q   <= '0;
      val_r_q    <= '0;
      psum_r_q   <= '0;
      op_w_q     <= OP_IDLE;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      sat_flag_q <= 1'b0;
    end else begin
      op_t_q     <= op_t_d;
      addr_t_q   <= addr_t_d;
      val_t_q    <= val_t_d;
      op_r_q     <= op_r_d;
      addr_r_q   <= addr_r_d;
      val_r_q    <= val_r_d;
      psum_r_q   <= psum_r_d;
      op_w_q     <= op_w_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      sat_flag_q <= sat_flag_d;
    end
  end

  // Partial-sum array: cleared on reset, written from W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        psum_q[i] <= '0;
      end
    end else if (w_we) begin
      psum_q[addr_r_q] <= sum_w;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.sat_flag = sat_flag_q;
  assign bus.busy     = (op_t_q != OP_IDLE) | (op_r_q != OP_IDLE) | (op_w_q != OP_IDLE);

endmodule

// File: tb/tb_acc_trunc_stage.sv
// tb_acc_trunc_stage
// Directed vectors with hand-computed expected psum values for the add stage.
module tb_acc_trunc_stage;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  acc_trunc_stage_if #(.DATA_W(16), .ACT_NO_W(6), .TRUNC_W(4)) bus ();

  acc_trunc_stage #(.DATA_W(16), .ACT_NO_W(6), .TRUNC_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef TRUNC_ROUND_EN
  localparam logic [15:0] EXP_NEG3_T1  = 16'hFFFF;
  localparam logic [15:0] EXP_MAXSHIFT = 16'h2469;
`else
  localparam logic [15:0] EXP_NEG3_T1  = 16'hFFFE;
  localparam logic [15:0] EXP_MAXSHIFT = 16'h2468;
`endif

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [5:0] addr,
                       input logic [3:0] tr, input logic [31:0] prod);
    bus.comp_en_add      = op;
    bus.out_act_addr_add = addr;
    bus.trunc_amount_add = tr;
    bus.mult_result_add  = prod;
    @(posedge clk);
    #1;
    bus.comp_en_add = 2'd0;
  endtask

  task automatic bubble(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle();
    int cnt;
    cnt = 0;
    while (bus.busy && cnt < 20) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    if (bus.busy) check_val("busy_timeout", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic drain_check(input string tag, input logic [5:0] addr, input logic [15:0] exp);
    bus.rd_en   = 1'b1;
    bus.rd_addr = addr;
    @(posedge clk);
    #1;
    bus.rd_en = 1'b0;
    check_val({tag, "_vld"}, {31'd0, bus.rd_valid}, 32'd1);
    check_val(tag, {16'd0, bus.rd_data}, {16'd0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    n_tests = 0;
    n_fail  = 0;
    rst_n                = 1'b0;
    bus.comp_en_add      = 2'd0;
    bus.out_act_addr_add = '0;
    bus.trunc_amount_add = '0;
    bus.mult_result_add  = '0;
    bus.rd_en            = 1'b0;
    bus.rd_addr          = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy",  {31'd0, bus.busy},     32'd0);
    check_val("rst_sat",   {31'd0, bus.sat_flag}, 32'd0);
    check_val("rst_rdvld", {31'd0, bus.rd_valid}, 32'd0);
    check_val("rst_rddat", {16'd0, bus.rd_data},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drain_check("rst_psum3", 6'd3, 16'h0000);

    // LOAD with trunc 4, busy right after capture, drain latency and hold
    issue(2'd2, 6'd3, 4'd4, 32'h0000_0500);
    check_val("busy_t", {31'd0, bus.busy}, 32'd1);
    wait_idle();
    drain_check("load3", 6'd3, 16'h0050);
    bubble(1);
    check_val("rdvld_drop", {31'd0, bus.rd_valid}, 32'd0);
    check_val("rddat_hold", {16'd0, bus.rd_data},  32'h0050);

    // Read sampled on the write edge sees the old value, next edge the new
    issue(2'd2, 6'd9, 4'd0, 32'h0000_1234);
    bubble(1);
    drain_check("rd_same_edge", 6'd9, 16'h0000);
    drain_check("rd_after",     6'd9, 16'h1234);

    // Back-to-back ACCs through the forwarding path: 10 + 4*7 = 38
    issue(2'd2, 6'd5, 4'd0, 32'd10);
    for (int i = 0; i < 4; i++) issue(2'd1, 6'd5, 4'd0, 32'd7);
    wait_idle();
    drain_check("fwd_b2b", 6'd5, 16'd38);

    // Same sum with IDLE bubbles interleaved
    issue(2'd2, 6'd6, 4'd0, 32'd10);
    issue(2'd1, 6'd6, 4'd0, 32'd7);
    bubble(1);
    issue(2'd1, 6'd6, 4'd0, 32'd7);
    bubble(2);
    issue(2'd1, 6'd6, 4'd0, 32'd7);
    issue(2'd1, 6'd6, 4'd0, 32'd7);
    wait_idle();
    drain_check("fwd_bubbles", 6'd6, 16'd38);

    // Negative odd product shifted by 1, and maximum shift amount
    issue(2'd2, 6'd13, 4'd1, 32'hFFFF_FFFD);
    issue(2'd2, 6'd14, 4'd15, 32'h1234_5678);
    wait_idle();
    drain_check("neg3_t1",  6'd13, EXP_NEG3_T1);
    drain_check("maxshift", 6'd14, EXP_MAXSHIFT);
    check_val("sat_clear", {31'd0, bus.sat_flag}, 32'd0);

    // T-stage clamp high, then ACC clamps at +max and -min
    issue(2'd2, 6'd10, 4'd0, 32'h7FFF_FFFF);
    wait_idle();
    check_val("sat_t", {31'd0, bus.sat_flag}, 32'd1);
    drain_check("tsat_hi", 6'd10, 16'h7FFF);
    issue(2'd1, 6'd10, 4'd0, 32'h0000_7FFF);
    issue(2'd2, 6'd11, 4'd0, 32'hFFFF_8000);
    issue(2'd1, 6'd11, 4'd0, 32'hFFFF_FFFF);
    wait_idle();
    drain_check("acc_sat_hi", 6'd10, 16'h7FFF);
    drain_check("acc_sat_lo", 6'd11, 16'h8000);

    // Reset while an ACC to addr 2 sits in R
    issue(2'd1, 6'd2, 4'd0, 32'd5);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("midrst_busy", {31'd0, bus.busy}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_val("postrst_busy", {31'd0, bus.busy},     32'd0);
    check_val("postrst_sat",  {31'd0, bus.sat_flag}, 32'd0);
    drain_check("postrst_p2",  6'd2,  16'h0000);
    drain_check("postrst_p10", 6'd10, 16'h0000);
    issue(2'd2, 6'd2, 4'd0, 32'd9);
    issue(2'd1, 6'd2, 4'd0, 32'd1);
    wait_idle();
    drain_check("postrst_op", 6'd2, 16'd10);

    // Reserved op: no write, no flag, but occupies busy for 3 cycles
    issue(2'd2, 6'd7, 4'd0, 32'h0000_0077);
    wait_idle();
    issue(2'd3, 6'd7, 4'd0, 32'h7FFF_FFFF);
    busy_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.busy) busy_cnt++;
      @(posedge clk);
      #1;
    end
    check_val("rsvd_busy", busy_cnt, 32'd3);
    drain_check("rsvd_psum7", 6'd7, 16'h0077);
    check_val("rsvd_sat", {31'd0, bus.sat_flag}, 32'd0);

    // W-stage clamp alone sets the sticky flag
    issue(2'd2, 6'd12, 4'd0, 32'h0000_7000);
    issue(2'd1, 6'd12, 4'd0, 32'h0000_7000);
    wait_idle();
    check_val("sat_w", {31'd0, bus.sat_flag}, 32'd1);
    drain_check("wsat_p12", 6'd12, 16'h7FFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/acc_trunc_stage.md
Name: acc_trunc_stage

Overview:
- Add stage of the PE pipeline, directly downstream of the multiply stage.
- Takes the registered 2*DATA_W signed product, the truncation amount, the output-activation address and the computation enable.
- Arithmetic-right-shifts the product and saturates it to DATA_W.
- Accumulates the result, with saturation, into a local partial-sum array indexed by output-activation address. The array has a read-out port for drain.

Parameters:
- DATA_W, 16, PE data width; the product is 2*DATA_W.
- ACT_NO_W, 6, output-activation address width; array depth is 2**ACT_NO_W.
- TRUNC_W, 4, truncation-amount width; shift range is 0..2**TRUNC_W-1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- comp_en_add  in  2  op code: 0 IDLE, 1 ACC (psum += value), 2 LOAD (psum = value), 3 reserved (treated as IDLE).
- out_act_addr_add  in  ACT_NO_W  psum address.
- trunc_amount_add  in  TRUNC_W  right-shift amount.
- mult_result_add  in  2*DATA_W  signed product.
- rd_en  in  1  drain read request.
- rd_addr  in  ACT_NO_W  drain read address.
- rd_data  out  DATA_W  drain read data.
- rd_valid  out  1  rd_data valid.
- busy  out  1  any non-IDLE op in stages T/R/W.
- sat_flag  out  1  sticky: any truncation or accumulation saturated since reset.

Behaviour:
- Reset values: all outputs 0; all psum entries 0; stage valid bits 0.
- Reset mid-operation discards in-flight ops; no partial write occurs.
- Pipeline, one op per cycle, no backpressure, three stages:
  - T, edge N+1: register shifted = product >>> trunc_amount (arithmetic). Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. Register value, addr, op.
  - R, edge N+2: synchronous read of psum[addr] into a register.
  - W, cycle N+2: compute sum = LOAD ? value : psum_r + value, in DATA_W+1 bits, saturated to DATA_W. Write to psum[addr] at edge N+3.
  - Result is visible via the drain port for rd_en asserted at or after edge N+3.
- Hazard forwarding:
  - If R's address equals W's address and W's op is valid, R captures W's sum instead of the array output.
  - If T's address equals W's address as T moves into R, the same rule applies via the W write.
  - Back-to-back ACCs to one address must produce the exact serial sum.
- IDLE and reserved ops propagate as bubbles: no read side effects, no write, no sat_flag contribution.
- sat_flag sets on any T-stage clamp or W-stage clamp of a valid op. It clears only on reset.
- busy = valid_T | valid_R | valid_W (combinational from stage registers).
- Drain port:
  - rd_en sampled at edge; rd_data = psum[rd_addr] and rd_valid = 1 one cycle later; otherwise rd_valid = 0 and rd_data holds.
  - Reads return committed contents only. A read and a W write to the same address in the same edge return the old value.
  - Drain reads are legal during ops; the upstream controller waits for busy = 0 before draining.
- trunc_amount = 0: value is the saturated low product. Maximum shift is legal.

Optional Feature:
- Macro: TRUNC_ROUND_EN.
- Defined: before the shift, add 2^(trunc_amount-1) (no add when the amount is 0), i.e. round-half-up, computed in 2*DATA_W+1 bits; then shift and saturate.
- Undefined: plain truncation toward negative infinity.
- Pipeline latency is unchanged either way.

Test Plan:
- Reset, then LOAD addr 3, product 0x0000_0500, trunc 4 -> psum[3] = 0x0050; drain read of addr 3 after busy = 0 returns 0x0050 with rd_valid 1 cycle after rd_en.
- LOAD addr 5 = 10, then four back-to-back ACC addr 5 of 7 (trunc 0) -> psum[5] = 38, proving forwarding; interleaved IDLE bubbles give the same result.
- Product 0x7FFF_FFFF, trunc 0 -> T saturates to 0x7FFF and sat_flag = 1; ACC of 0x7FFF onto 0x7FFF -> psum = 0x7FFF; negative case -0x8000 + -1 -> psum = 0x8000.
- Product -3 (0xFFFF_FFFD), trunc 1 -> -2 without TRUNC_ROUND_EN; -1 with it defined.
- rst_n asserted while ACC to addr 2 is in stage R -> psum[2] = 0, busy = 0, sat_flag = 0 after release; next op behaves normally.
- comp_en = 3 with addr 7 -> psum[7] unchanged, no sat_flag, busy high for 3 cycles.
